// File: rtl/cordic_iter_core_if.sv
// cordic_iter_core_if: sample-in / result-out handshake bundle for the CORDIC core.
// Upstream side: first-octant sample plus sideband, valid/ready.
// Downstream side: magnitude/phase plus sideband, valid/ready.
interface cordic_iter_core_if;
  logic [11:0] in_re;
  logic [11:0] in_im;
  logic [1:0]  in_quadrant_id;
  logic        in_exchanged;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] out_magnitude;
  logic [11:0] out_phase;
  logic [1:0]  out_quadrant_id;
  logic        out_exchanged;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_re, in_im, in_quadrant_id, in_exchanged, in_valid, out_ready,
    input  in_ready, out_magnitude, out_phase, out_quadrant_id, out_exchanged, out_valid
  );

  modport slave (
    input  in_re, in_im, in_quadrant_id, in_exchanged, in_valid, out_ready,
    output in_ready, out_magnitude, out_phase, out_quadrant_id, out_exchanged, out_valid
  );
endinterface

// File: rtl/cordic_iter_core.sv
// cordic_iter_core: iterative CORDIC vectoring of a first-octant sample into magnitude/phase.
// Latency: out_valid NB_ITER+1 cycles after the transfer edge; one sample per NB_ITER+2 cycles.
// Backpressure: result held stable while out_ready is low; no new sample taken until it is consumed.
module cordic_iter_core #(
  parameter int NB_ITER = 10
) (
  input logic               clk,
  input logic               rst,
  cordic_iter_core_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] LAST_I = 4'(NB_ITER - 1);

  logic [1:0]         state_q, state_d;
  logic signed [14:0] x_q, x_d;
  logic signed [14:0] y_q, y_d;
  logic signed [12:0] z_q, z_d;
  logic [3:0]         i_q, i_d;
  logic [1:0]         quad_q, quad_d;
  logic               exch_q, exch_d;
  logic               zero_q, zero_d;

  logic signed [12:0] atan_val;
  logic signed [14:0] x_sh;
  logic signed [14:0] y_sh;
  logic               take;
  logic               mag_unused;
  logic [11:0]        phase;

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = (state_q == S_DONE) && !rst;
  assign take          = bus.in_valid && bus.in_ready;

  // Arctangent of 2^-i in units of 2*pi/4096.
  always_comb begin
    case (i_q)
      4'd0:    atan_val = 13'sd512;
      4'd1:    atan_val = 13'sd302;
      4'd2:    atan_val = 13'sd160;
      4'd3:    atan_val = 13'sd81;
      4'd4:    atan_val = 13'sd41;
      4'd5:    atan_val = 13'sd20;
      4'd6:    atan_val = 13'sd10;
      4'd7:    atan_val = 13'sd5;
      4'd8:    atan_val = 13'sd3;
      4'd9:    atan_val = 13'sd1;
      4'd10:   atan_val = 13'sd1;
      default: atan_val = 13'sd0;
    endcase
  end

  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;

  // Next state: load on transfer, one micro-rotation per ITER cycle, hold in DONE until taken.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    quad_d  = quad_q;
    exch_d  = exch_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          x_d     = {3'b000, bus.in_re};
          y_d     = {3'b000, bus.in_im};
          z_d     = 13'sd0;
          i_d     = 4'd0;
          quad_d  = bus.in_quadrant_id;
          exch_d  = bus.in_exchanged;
          // A zero vector has no angle; the rotations would otherwise drift z to full scale.
          zero_d  = (bus.in_re == 12'd0) && (bus.in_im == 12'd0);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (!y_q[14]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_val;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_val;
        end
        i_d = i_q + 4'd1;
        if (i_q == LAST_I) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset that discards any sample in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      quad_q  <= '0;
      exch_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      quad_q  <= quad_d;
      exch_q  <= exch_d;
      zero_q  <= zero_d;
    end
  end

  // Phase clamped to the octant range 0..512.
  always_comb begin
    if (zero_q || z_q[12]) begin
      phase = 12'd0;
    end else if (z_q > 13'sd512) begin
      phase = 12'd512;
    end else begin
      phase = z_q[11:0];
    end
  end

  // Magnitude never reaches bit 14 for legal inputs.
  assign mag_unused          = x_q[14];
  assign bus.out_magnitude   = x_q[13:0];
  assign bus.out_phase       = phase;
  assign bus.out_quadrant_id = quad_q;
  assign bus.out_exchanged   = exch_q;

endmodule

// File: tb/tb_cordic_iter_core.sv
// tb_cordic_iter_core: directed vectors with hand-computed expectations for cordic_iter_core.
// Inputs are driven just after clock edges; outputs are sampled on the falling edge.
// Covers reset, latency, accuracy, clamping, stall, mid-run reset and back-to-back throughput.
module tb_cordic_iter_core;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  int   cyc;

  cordic_iter_core_if bus();

  cordic_iter_core #(.NB_ITER(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
    n_checks++;
    if (obs < exp - tol || obs > exp + tol) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  // Called just after a falling edge; returns just after the transfer edge.
  task automatic push(input logic [11:0] re, input logic [11:0] im,
                      input logic [1:0] q, input logic ex);
    int guard;
    guard = 0;
    bus.in_re          = re;
    bus.in_im          = im;
    bus.in_quadrant_id = q;
    bus.in_exchanged   = ex;
    bus.in_valid       = 1'b1;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts falling edges after the transfer edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 60);
  endtask

  int lat;
  int t_xfer[$];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    bus.in_re = '0;
    bus.in_im = '0;
    bus.in_quadrant_id = '0;
    bus.in_exchanged = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_mag", int'(bus.out_magnitude), 0);
    chk("rst_phase", int'(bus.out_phase), 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", int'(bus.in_ready), 1);

    // 1000 + j0: first transfer on the first edge after reset release
    push(12'd1000, 12'd0, 2'b00, 1'b0);
    wait_result(lat);
    chk("lat_1000_0", lat, 11);
    chk("mag_1000_0", int'(bus.out_magnitude), 1647, 4);
    chk("ph_1000_0", int'(bus.out_phase), 0, 2);
    chk("in_ready_done", int'(bus.in_ready), 0);

    // 1000 + j1000: 45 degrees, phase at the clamp boundary
    push(12'd1000, 12'd1000, 2'b01, 1'b0);
    wait_result(lat);
    chk("lat_1000_1000", lat, 11);
    chk("mag_1000_1000", int'(bus.out_magnitude), 2329, 4);
    chk("ph_1000_1000", int'(bus.out_phase), 511, 1);
    chk("quad_01", int'(bus.out_quadrant_id), 1);

    // Full scale 45 degrees, no overflow
    push(12'd4095, 12'd4095, 2'b10, 1'b1);
    wait_result(lat);
    chk("mag_4095", int'(bus.out_magnitude), 9537, 6);
    chk("ph_4095", int'(bus.out_phase), 511, 1);
    chk("exch_4095", int'(bus.out_exchanged), 1);

    // Zero vector
    push(12'd0, 12'd0, 2'b00, 1'b0);
    wait_result(lat);
    chk("mag_zero", int'(bus.out_magnitude), 0);
    chk("ph_zero", int'(bus.out_phase), 0);

    // Stall: result held while out_ready is low
    @(negedge clk);
    bus.out_ready = 1'b0;
    push(12'd1000, 12'd0, 2'b11, 1'b1);
    wait_result(lat);
    chk("lat_stall", lat, 11);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", int'(bus.out_valid), 1);
      chk("stall_mag", int'(bus.out_magnitude), 1647, 4);
      chk("stall_phase", int'(bus.out_phase), 0, 2);
      chk("stall_quad", int'(bus.out_quadrant_id), 3);
      chk("stall_exch", int'(bus.out_exchanged), 1);
      chk("stall_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_consumed", int'(bus.out_valid), 0);
    chk("stall_idle", int'(bus.in_ready), 1);

    // Reset during iteration 4 aborts the sample
    push(12'd1000, 12'd0, 2'b00, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_in_ready_rst", int'(bus.in_ready), 0);
    rst = 1'b0;
    #1 chk("abort_idle", int'(bus.in_ready), 1);
    push(12'd500, 12'd0, 2'b00, 1'b0);
    wait_result(lat);
    chk("lat_500", lat, 11);
    chk("mag_500", int'(bus.out_magnitude), 823, 4);
    chk("ph_500", int'(bus.out_phase), 0, 2);

    // Back-to-back throughput with in_valid held high
    @(negedge clk);
    bus.in_re = 12'd1000;
    bus.in_im = 12'd0;
    bus.in_quadrant_id = 2'b00;
    bus.in_exchanged = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 60 && t_xfer.size() < 3; k++) begin
      if (bus.in_valid && bus.in_ready) t_xfer.push_back(cyc);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("b2b_count", t_xfer.size(), 3);
    if (t_xfer.size() == 3) begin
      chk("b2b_gap1", t_xfer[1] - t_xfer[0], 12);
      chk("b2b_gap2", t_xfer[2] - t_xfer[1], 12);
    end
    wait_result(lat);
    chk("b2b_mag", int'(bus.out_magnitude), 1647, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
